alarm_sounder: RTL and testbench
================================

Name: alarm_sounder

Overview:
- Downstream consumer of the alarm FSM's `alarm_on` level.
- Turns that level into the user-facing alarm: a gated square-wave buzzer tone with on/off cadence, snooze, stop/acknowledge, auto-timeout and a status LED.
- Runs on the system clock with internal prescalers.
- Top level drives its `alarm_led` output from this block instead of wiring `alarm_on` straight through.

Parameters:
- TICK_DIV, 100_000: clk cycles per 1 ms tick.
- MS_PER_S, 1000: ms ticks per second tick.
- TONE_DIV, 25_000: clk cycles per tone half-period (2 kHz at 100 MHz).
- BEEP_ON_MS, 200: ms of tone per cadence period.
- BEEP_OFF_MS, 300: ms of silence per cadence period.
- SNOOZE_S, 300: snooze length in seconds.
- TIMEOUT_S, 60: ring time in seconds before auto-off.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- alarm_on  in  1  level from alarm FSM; high while current time matches alarm time.
- btn_snooze  in  1  debounced level.
- btn_stop  in  1  debounced level.
- buzzer  out  1  tone output.
- alarm_led  out  1  alarm status LED.
- snoozing  out  1  high in SNOOZE.
- state  out  2  current state: 0 IDLE, 1 RING, 2 SNOOZE, 3 LOCKOUT.

Behaviour:
- Reset (reset==0 sampled at a clk edge):
  - state=IDLE; buzzer, alarm_led, snoozing = 0.
  - All prescalers, cadence, second counters and edge-detect registers cleared.
  - Applies mid-operation from any state, with no residual tone.
- Button edges:
  - Button events are rising edges only; registered previous value is compared with current value.
  - A held button produces one event.
  - Previous-value registers reset to 0, so a button held through reset release produces one event.
- Prescalers:
  - ms_tick is a 1-cycle pulse every TICK_DIV clk.
  - s_tick is a 1-cycle pulse every MS_PER_S ms_ticks.
  - Both prescalers and the second counter restart from 0 on every state entry, so durations are exact from the entry edge.
- States (all transitions registered, taking effect on the edge where the condition is sampled):
  - IDLE: alarm_on==1 -> RING.
  - RING:
    - stop event -> LOCKOUT.
    - otherwise snooze event -> SNOOZE.
    - otherwise TIMEOUT_S s_ticks elapsed since entry -> LOCKOUT.
    - Priority: stop > snooze > timeout when simultaneous.
  - SNOOZE:
    - stop event -> LOCKOUT.
    - SNOOZE_S s_ticks elapsed -> RING, regardless of alarm_on.
    - Snooze events are ignored.
  - LOCKOUT: alarm_on==0 -> IDLE. It prevents re-ringing within the same matching minute.
    - If alarm_on is already 0 on entry, the state moves to IDLE on the next edge.
- Cadence (RING only):
  - ms counter runs 0..BEEP_ON_MS+BEEP_OFF_MS-1 and wraps.
  - It restarts at 0 on each RING entry, including re-entry from SNOOZE.
  - Beep phase is count < BEEP_ON_MS.
- Tone:
  - tone_reg toggles every TONE_DIV clk while in RING.
  - tone_reg is cleared to 0 on RING entry and on every cadence wrap.
  - buzzer = tone_reg AND beep phase AND state==RING, and is registered.
  - buzzer is 0 in every other state within 1 cycle of leaving RING.
- alarm_led:
  - 1 in RING (steady).
  - In SNOOZE, equals bit 0 of the second counter (0.5 Hz blink, starting at 0).
  - 0 in IDLE and LOCKOUT.
- snoozing = (state==SNOOZE).
- All outputs are registered, so they appear 1 cycle after the state change.
- Width rules:
  - Each counter is sized $clog2 of its terminal count.
  - Counters wrap only at their terminal count and never overflow.

Test Plan (TICK_DIV=10, MS_PER_S=5 (50 clk/s), TONE_DIV=2, BEEP_ON_MS=2, BEEP_OFF_MS=3, SNOOZE_S=2, TIMEOUT_S=3):
- Release reset, hold alarm_on=0 for 100 cycles -> state=0, buzzer=alarm_led=0 throughout.
- Raise alarm_on -> state=1 next edge, alarm_led=1 one cycle later. buzzer toggles every 2 clk for 20 clk, then stays low for 30 clk, repeating with a 50-clk period.
- Ring with no buttons, alarm_on held -> LOCKOUT exactly 150 clk after RING entry, buzzer=0. Drop alarm_on -> IDLE next edge.
- Snooze pulse during RING -> state=2, snoozing=1, buzzer=0. alarm_led is 0 for 50 clk, then 1 for 50 clk. After 100 clk -> RING with cadence restarted (tone burst within 2 clk).
- btn_stop and btn_snooze rise on the same edge in RING -> LOCKOUT (not SNOOZE). Holding btn_stop for 200 clk produces no further effect.
- Pull reset low mid-beep in RING -> next edge state=0, buzzer=0, alarm_led=0. With alarm_on still 1 after release -> RING again, cadence from 0.

Source files
------------

// File: rtl/alarm_sounder.sv
// Alarm sounder: turns the alarm FSM's alarm_on level into a cadenced buzzer tone
// with snooze, stop, auto-timeout and a status LED, all timed by internal prescalers.
module alarm_sounder #(
  parameter int TICK_DIV    = 100_000,
  parameter int MS_PER_S    = 1000,
  parameter int TONE_DIV    = 25_000,
  parameter int BEEP_ON_MS  = 200,
  parameter int BEEP_OFF_MS = 300,
  parameter int SNOOZE_S    = 300,
  parameter int TIMEOUT_S   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_on,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       buzzer,
  output logic       alarm_led,
  output logic       snoozing,
  output logic [1:0] state
);

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PERIOD_MS = BEEP_ON_MS + BEEP_OFF_MS;
  localparam int SEC_MAX   = (TIMEOUT_S > SNOOZE_S) ? TIMEOUT_S : SNOOZE_S;
  localparam int TW = cnt_width(TICK_DIV);
  localparam int MW = cnt_width(MS_PER_S);
  localparam int CW = cnt_width(PERIOD_MS);
  localparam int SW = cnt_width(SEC_MAX);
  localparam int NW = cnt_width(TONE_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RING    = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t        state_r, next_state_s;
  logic          prev_stop_r, prev_snooze_r;
  logic [TW-1:0] tick_cnt_r;
  logic [MW-1:0] ms_cnt_r;
  logic [SW-1:0] sec_cnt_r;
  logic [CW-1:0] cad_cnt_r;
  logic [NW-1:0] tone_cnt_r;
  logic          tone_r;

  logic stop_ev_s, snooze_ev_s, enter_s;
  logic ms_tick_s, s_tick_s, cad_wrap_s, tone_flip_s, beep_s;
  logic buzzer_s, led_s;

  assign stop_ev_s   = btn_stop & ~prev_stop_r;
  assign snooze_ev_s = btn_snooze & ~prev_snooze_r;
  assign enter_s     = (next_state_s != state_r);
  assign ms_tick_s   = (tick_cnt_r == TW'(TICK_DIV - 1));
  assign s_tick_s    = ms_tick_s && (ms_cnt_r == MW'(MS_PER_S - 1));
  assign cad_wrap_s  = ms_tick_s && (cad_cnt_r == CW'(PERIOD_MS - 1));
  assign tone_flip_s = (tone_cnt_r == NW'(TONE_DIV - 1));
  assign beep_s      = (cad_cnt_r < CW'(BEEP_ON_MS));
  assign state       = state_r;

  // Next-state decision and the values the output registers will capture
  always_comb begin
    next_state_s = state_r;
    buzzer_s     = 1'b0;
    led_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (alarm_on) next_state_s = RING;
        else          next_state_s = IDLE;
      end
      RING: begin
        buzzer_s = tone_r & beep_s;
        led_s    = 1'b1;
        if (stop_ev_s)        next_state_s = LOCKOUT;
        else if (snooze_ev_s) next_state_s = SNOOZE;
        else if (s_tick_s && (sec_cnt_r == SW'(TIMEOUT_S - 1))) next_state_s = LOCKOUT;
        else                  next_state_s = RING;
      end
      SNOOZE: begin
        led_s = sec_cnt_r[0];
        if (stop_ev_s) next_state_s = LOCKOUT;
        else if (s_tick_s && (sec_cnt_r == SW'(SNOOZE_S - 1))) next_state_s = RING;
        else           next_state_s = SNOOZE;
      end
      LOCKOUT: begin
        if (!alarm_on) next_state_s = IDLE;
        else           next_state_s = LOCKOUT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, button edge history and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      prev_stop_r   <= 1'b0;
      prev_snooze_r <= 1'b0;
      buzzer        <= 1'b0;
      alarm_led     <= 1'b0;
      snoozing      <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      prev_stop_r   <= btn_stop;
      prev_snooze_r <= btn_snooze;
      buzzer        <= buzzer_s;
      alarm_led     <= led_s;
      snoozing      <= (state_r == SNOOZE);
    end
  end

  // Prescalers, cadence and tone; every state entry restarts timing from zero
  always_ff @(posedge clk) begin
    if (!reset || enter_s) begin
      tick_cnt_r <= '0;
      ms_cnt_r   <= '0;
      sec_cnt_r  <= '0;
      cad_cnt_r  <= '0;
      tone_cnt_r <= '0;
      tone_r     <= 1'b0;
    end else begin
      tick_cnt_r <= ms_tick_s ? '0 : tick_cnt_r + TW'(1);
      if (ms_tick_s) begin
        ms_cnt_r <= (ms_cnt_r == MW'(MS_PER_S - 1)) ? '0 : ms_cnt_r + MW'(1);
      end
      if (s_tick_s) begin
        sec_cnt_r <= (sec_cnt_r == SW'(SEC_MAX - 1)) ? '0 : sec_cnt_r + SW'(1);
      end
      if (state_r == RING) begin
        if (ms_tick_s) begin
          cad_cnt_r <= cad_wrap_s ? '0 : cad_cnt_r + CW'(1);
        end
        // A cadence wrap restarts the tone so every burst has the same phase
        if (cad_wrap_s) begin
          tone_cnt_r <= '0;
          tone_r     <= 1'b0;
        end else if (tone_flip_s) begin
          tone_cnt_r <= '0;
          tone_r     <= ~tone_r;
        end else begin
          tone_cnt_r <= tone_cnt_r + NW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alarm_sounder.sv
// Scoreboard bench for alarm_sounder: a time-since-entry reference model pushes the
// expected post-edge outputs each cycle; they are popped and compared after the edge.
module tb_alarm_sounder;

  localparam int TICK_DIV    = 10;
  localparam int MS_PER_S    = 5;
  localparam int TONE_DIV    = 2;
  localparam int BEEP_ON_MS  = 2;
  localparam int BEEP_OFF_MS = 3;
  localparam int SNOOZE_S    = 2;
  localparam int TIMEOUT_S   = 3;
  localparam int CLK_S       = TICK_DIV * MS_PER_S;
  localparam int PERIOD_CLK  = (BEEP_ON_MS + BEEP_OFF_MS) * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alarm_on = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       btn_stop = 1'b0;
  logic       buzzer, alarm_led, snoozing;
  logic [1:0] state;

  alarm_sounder #(
    .TICK_DIV(TICK_DIV), .MS_PER_S(MS_PER_S), .TONE_DIV(TONE_DIV),
    .BEEP_ON_MS(BEEP_ON_MS), .BEEP_OFF_MS(BEEP_OFF_MS),
    .SNOOZE_S(SNOOZE_S), .TIMEOUT_S(TIMEOUT_S)
  ) dut (
    .clk(clk), .reset(reset), .alarm_on(alarm_on),
    .btn_snooze(btn_snooze), .btn_stop(btn_stop),
    .buzzer(buzzer), .alarm_led(alarm_led), .snoozing(snoozing), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       bz;
    logic       led;
    logic       sn;
  } exp_t;

  exp_t exp_q[$];
  int   m_state = 0;
  int   m_k = 0;
  logic m_prev_stop = 1'b0;
  logic m_prev_snooze = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    exp_t got_e;
    int   p;
    int   nxt;
    logic stop_ev, snooze_ev;
    if (!reset) begin
      e = '0;
      m_state = 0;
      m_k = 0;
      m_prev_stop = 1'b0;
      m_prev_snooze = 1'b0;
    end else begin
      p = m_k % PERIOD_CLK;
      e.bz  = (m_state == 1) && (p < BEEP_ON_MS * TICK_DIV) && (((p / TONE_DIV) % 2) == 1);
      e.led = (m_state == 1) ? 1'b1 : (m_state == 2) ? (((m_k / CLK_S) % 2) == 1) : 1'b0;
      e.sn  = (m_state == 2);
      stop_ev   = btn_stop && !m_prev_stop;
      snooze_ev = btn_snooze && !m_prev_snooze;
      nxt = m_state;
      case (m_state)
        0: if (alarm_on) nxt = 1;
        1: begin
          if (stop_ev) nxt = 3;
          else if (snooze_ev) nxt = 2;
          else if (m_k == TIMEOUT_S * CLK_S - 1) nxt = 3;
        end
        2: begin
          if (stop_ev) nxt = 3;
          else if (m_k == SNOOZE_S * CLK_S - 1) nxt = 1;
        end
        3: if (!alarm_on) nxt = 0;
        default: nxt = 0;
      endcase
      m_k = (nxt != m_state) ? 0 : m_k + 1;
      m_state = nxt;
      e.st = nxt[1:0];
      m_prev_stop = btn_stop;
      m_prev_snooze = btn_snooze;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    check_val("state", {30'd0, state}, {30'd0, got_e.st});
    check_val("buzzer", {31'd0, buzzer}, {31'd0, got_e.bz});
    check_val("alarm_led", {31'd0, alarm_led}, {31'd0, got_e.led});
    check_val("snoozing", {31'd0, snoozing}, {31'd0, got_e.sn});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset, then a quiet idle stretch
    run(3);
    reset = 1'b1;
    run(100);

    // ring with no buttons until the auto-timeout, then drop alarm_on
    alarm_on = 1'b1;
    run(160);
    alarm_on = 1'b0;
    run(3);

    // snooze (held for a few cycles), re-ring, snooze again, stop while snoozing
    alarm_on = 1'b1;
    run(30);
    btn_snooze = 1'b1;
    run(5);
    btn_snooze = 1'b0;
    run(110);
    btn_snooze = 1'b1;
    run(1);
    btn_snooze = 1'b0;
    run(20);
    btn_snooze = 1'b1;
    run(1);
    btn_snooze = 1'b0;
    run(10);
    btn_stop = 1'b1;
    run(1);
    btn_stop = 1'b0;
    run(5);
    alarm_on = 1'b0;
    run(3);

    // stop and snooze on the same edge, stop then held
    alarm_on = 1'b1;
    run(25);
    btn_stop = 1'b1;
    btn_snooze = 1'b1;
    run(1);
    btn_snooze = 1'b0;
    run(200);
    alarm_on = 1'b0;
    run(2);
    btn_stop = 1'b0;
    run(2);

    // reset pulled mid-beep with alarm_on held and snooze held through reset
    alarm_on = 1'b1;
    run(12);
    reset = 1'b0;
    btn_snooze = 1'b1;
    run(1);
    reset = 1'b1;
    run(60);
    btn_snooze = 1'b0;
    run(5);

    // random button and alarm activity
    for (int i = 0; i < 600; i++) begin
      btn_stop   = ($urandom_range(0, 60) == 0);
      btn_snooze = ($urandom_range(0, 25) == 0) ? ~btn_snooze : btn_snooze;
      if ($urandom_range(0, 80) == 0) alarm_on = ~alarm_on;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
